muldiv_gen: RTL and testbench
=============================

Name: muldiv_gen

Overview:
Parametrised iterative multiplier/divider for the console bus domain. It computes a W x W multiply or a 2W / W divide, unsigned or two's-complement signed, one bit per enabled cycle. It adds a start/busy/done handshake and defined divide-by-zero and overflow results. It is bus-agnostic; a thin register decoder in the console drives it.

Parameters:
W, 8, operand width: multiplicand, multiplier and divisor are W bits; dividend, product, quotient and remainder registers are 2W bits.
SIGNED_EN, 1, when 0 the sgn input is ignored and the fixup cycle logic is removed.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  clock enable; all state advances only on clk edges with cpu_en=1 ("tick")
start  in  1  begin an operation on this tick
op  in  1  0 = multiply, 1 = divide (muldiv_pkg::md_op_t)
sgn  in  1  1 = signed operands and results
a  in  2W  dividend; multiplicand is a[W-1:0], a[2W-1:W] is ignored for multiply
b  in  W  multiplier or divisor
busy  out  1  operation in progress
done  out  1  single-tick pulse: results are final
res_1  out  2W  quotient (divide); all zero for multiply
res_2  out  2W  product (multiply) or remainder (divide)

Behaviour:
- Reset: busy=0, done=0, res_1=0, res_2=0, counter=0, FSM=IDLE. A reset mid-operation aborts the operation and no done pulse is issued.
- Inputs are sampled only on a tick with start=1. a, b, op and sgn are latched then and may change afterwards.
- FSM states: IDLE -> ITER -> (FIX if sgn & SIGNED_EN) -> IDLE.
  - Start tick: latch the operands, converting to magnitudes if signed. Clear res_1/res_2. Set counter=0. Enter ITER. busy=1 from the next clk.
  - ITER: one bit per tick. Multiply runs W ticks, shift-add, MSB of the multiplier first or LSB first (implementer's choice). Divide runs 2W ticks, restoring, MSB of the dividend first: shift the remainder in, subtract b, set the quotient bit if there is no borrow.
  - FIX (1 tick): apply signs. Product is negated if sa^sb. Quotient is negated if sa^sb. Remainder is negated if sa (remainder takes the dividend's sign; quotient truncates toward zero).
  - The final ITER tick (unsigned) or the FIX tick (signed) writes the final results, sets done=1 and busy=0 on the same clk edge.
- done is cleared on the next tick. While cpu_en=0, done, busy and results hold.
- Latency in ticks from the start tick to the done tick:
  - unsigned multiply: W
  - signed multiply: W+1
  - unsigned divide: 2W
  - signed divide: 2W+1
- res_1/res_2 are unspecified while busy=1. Software reads them only after done or when busy=0.
- start while busy aborts the current operation and restarts with the new operands. No done is issued for the aborted operation.
- start with cpu_en=0 is ignored.
- Divide by zero (b=0): full normal latency. res_1 = all ones, res_2 = a as latched (raw, not sign-adjusted). In signed mode FIX is skipped but still consumes its tick. busy/done timing is unchanged.
- Signed overflow, a = -2^(2W-1) and b = -1: res_1 = 2^(2W-1) (wraps to the most negative value), res_2 = 0. This falls out of the magnitude algorithm; no special case is required.
- Signed multiply: the most negative W-bit operands are handled by W-bit unsigned magnitude. -2^(W-1) * -2^(W-1) is exact.
- Arithmetic widths:
  - divide datapath: 2W+1 bits (borrow bit)
  - multiply accumulator: 2W bits
  - counter: clog2(2W+1) bits

Decomposition:
- muldiv_pkg holds:
  - typedef enum md_op_t {MD_MUL, MD_DIV}
  - typedef enum md_state_t {MD_IDLE, MD_ITER, MD_FIX}
  - a function md_latency(op, sgn, W) for benches
- One natural sub-module: muldiv_negate. It is a combinational conditional two's-complement, parametrised by width, and is instanced for operand magnitudes and for the FIX step.

Test Plan:
1. W=8, unsigned multiply, a=0x00FF, b=0xFF -> done on tick 8, res_2=0xFE01, res_1=0x0000, busy high ticks 1..7.
2. Unsigned divide, a=0x1234, b=0x56 -> done on tick 16, res_1=0x0036, res_2=0x0010.
3. Divide by zero, a=0xABCD, b=0x00 -> unsigned: done on tick 16, res_1=0xFFFF, res_2=0xABCD; same inputs with sgn=1: done on tick 17, same results.
4. Signed: multiply a=0x00FE, b=0x03 -> tick 9, res_2=0xFFFA. Divide a=0xFF9C, b=0x07 -> tick 17, res_1=0xFFF2, res_2=0xFFFE. Divide a=0x8000, b=0xFF -> res_1=0x8000, res_2=0x0000.
5. Handshake: start a divide, deassert cpu_en for 5 clks mid-operation -> busy, results and counter hold, done arrives 5 clks late with correct values. Restart with a multiply at tick 6 -> only one done, with the multiply result.
6. Assert reset at tick 4 of a divide -> next clk: busy=0, done=0, res_1=res_2=0, no done pulse afterwards. A new start then completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and bench helpers for the iterative multiplier/divider.
package muldiv_pkg;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // Ticks from the start tick to the done tick.
    function automatic int unsigned md_latency(md_op_t op, logic sgn, int unsigned w);
        int unsigned base;
        base = (op == MD_MUL) ? w : 2 * w;
        return base + (sgn ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/muldiv_gen_if.sv
// Command/result bundle between the console register decoder and muldiv_gen.
interface muldiv_gen_if #(
    parameter int W = 8
) ();
    import muldiv_pkg::*;

    logic           cpu_en;
    logic           start;
    md_op_t         op;
    logic           sgn;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] res_1;
    logic [2*W-1:0] res_2;

    modport master (
        output cpu_en, start, op, sgn, a, b,
        input  busy, done, res_1, res_2
    );

    modport slave (
        input  cpu_en, start, op, sgn, a, b,
        output busy, done, res_1, res_2
    );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: passes i_val through, or negates it when i_en is set.
module muldiv_negate #(
    parameter int N = 8
) (
    input  logic         i_en,
    input  logic [N-1:0] i_val,
    output logic [N-1:0] o_val
);
    assign o_val = i_en ? ((~i_val) + N'(1)) : i_val;
endmodule

// File: rtl/muldiv_gen.sv
// Iterative W x W multiply / 2W / W restoring divide, one bit per enabled tick,
// with sign handling done on magnitudes and a single fixup tick.
module muldiv_gen
    import muldiv_pkg::*;
#(
    parameter int W         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_gen_if.slave  bus
);
    localparam int W2 = 2 * W;
    localparam int CW = $clog2(W2 + 1);

    md_state_t      r_state;
    md_state_t      w_state_next;
    md_op_t         r_op;
    logic           r_sgn;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_div0;
    logic           r_done;
    logic [CW-1:0]  r_cnt;
    logic [W2-1:0]  r_x;
    logic [W-1:0]   r_y;
    logic [W2-1:0]  r_hi;
    logic [W2-1:0]  r_q;

    logic           w_sgn;
    logic           w_sa;
    logic           w_sb;
    logic           w_is_mul;
    logic [W2-1:0]  w_a_sel;
    logic [W2-1:0]  w_a_mag;
    logic [W2-1:0]  w_a_start;
    logic [W-1:0]   w_b_mag;
    logic           w_last;
    logic           w_finish;
    logic [W2:0]    w_rem_sh;
    logic [W2:0]    w_diff;
    logic           w_borrow;
    logic [W2-1:0]  w_prod_sum;
    logic           w_fix_hi_en;
    logic           w_fix_q_en;
    logic [W2-1:0]  w_fix_hi;
    logic [W2-1:0]  w_fix_q;

    // Operand magnitudes; the multiplicand is only the low W bits of a.
    assign w_sgn     = bus.sgn & SIGNED_EN;
    assign w_is_mul  = (bus.op == MD_MUL);
    assign w_sa      = w_sgn & (w_is_mul ? bus.a[W-1] : bus.a[W2-1]);
    assign w_sb      = w_sgn & bus.b[W-1];
    assign w_a_sel   = w_is_mul ? {{W{1'b0}}, bus.a[W-1:0]} : bus.a;
    assign w_a_start = w_is_mul ? {{W{1'b0}}, w_a_mag[W-1:0]} : w_a_mag;

    muldiv_negate #(.N(W2)) u_neg_a (.i_en(w_sa), .i_val(w_a_sel), .o_val(w_a_mag));
    muldiv_negate #(.N(W))  u_neg_b (.i_en(w_sb), .i_val(bus.b),   .o_val(w_b_mag));

    // Divide step: shift the next dividend bit into the remainder, trial-subtract.
    assign w_rem_sh   = {r_hi, r_x[W2-1]};
    assign w_diff     = w_rem_sh - {{(W + 1){1'b0}}, r_y};
    assign w_borrow   = w_diff[W2];
    assign w_prod_sum = r_hi + (r_y[0] ? r_x : '0);

    assign w_last = (r_op == MD_MUL) ? (r_cnt == CW'(W - 1)) : (r_cnt == CW'(W2 - 1));

    // A zero divisor leaves the quotient at all ones and the remainder at |a|,
    // so re-applying the dividend sign restores the raw a.
    assign w_fix_hi_en = (r_op == MD_MUL) ? r_neg_q : r_neg_r;
    assign w_fix_q_en  = (r_op == MD_DIV) & r_neg_q & ~r_div0;

    muldiv_negate #(.N(W2)) u_neg_hi (.i_en(w_fix_hi_en), .i_val(r_hi), .o_val(w_fix_hi));
    muldiv_negate #(.N(W2)) u_neg_q  (.i_en(w_fix_q_en),  .i_val(r_q),  .o_val(w_fix_q));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        if (bus.cpu_en) begin
            if (bus.start) begin
                w_state_next = MD_ITER;
            end else begin
                case (r_state)
                    MD_ITER: begin
                        if (w_last) begin
                            if (r_sgn) begin
                                w_state_next = MD_FIX;
                            end else begin
                                w_state_next = MD_IDLE;
                                w_finish     = 1'b1;
                            end
                        end
                    end
                    MD_FIX: begin
                        w_state_next = MD_IDLE;
                        w_finish     = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= MD_MUL;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_hi    <= '0;
            r_q     <= '0;
        end else if (bus.cpu_en) begin
            r_done <= w_finish;
            if (bus.start) begin
                r_op    <= bus.op;
                r_sgn   <= w_sgn;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_div0  <= (bus.b == '0);
                r_cnt   <= '0;
                r_x     <= w_a_start;
                r_y     <= w_b_mag;
                r_hi    <= '0;
                r_q     <= '0;
            end else begin
                case (r_state)
                    MD_ITER: begin
                        r_cnt <= r_cnt + CW'(1);
                        r_x   <= r_x << 1;
                        if (r_op == MD_MUL) begin
                            r_hi <= w_prod_sum;
                            r_y  <= r_y >> 1;
                        end else begin
                            r_hi <= w_borrow ? w_rem_sh[W2-1:0] : w_diff[W2-1:0];
                            r_q  <= {r_q[W2-2:0], ~w_borrow};
                        end
                    end
                    MD_FIX: begin
                        r_hi <= w_fix_hi;
                        r_q  <= w_fix_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy  = (r_state != MD_IDLE);
    assign bus.done  = r_done;
    assign bus.res_1 = r_q;
    assign bus.res_2 = r_hi;

endmodule

// File: tb/tb_muldiv_gen.sv
// Directed bench for muldiv_gen (W=8): arithmetic, latency, stall, abort and reset.
module tb_muldiv_gen;
    import muldiv_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_gen_if #(.W(W)) bus ();

    muldiv_gen #(.W(W), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clocks until done is seen; n = clocks waited, -1 on timeout.
    task automatic wait_done(input int max, output int n, output bit busy_ok);
        bit found;
        found   = 1'b0;
        busy_ok = 1'b1;
        n       = -1;
        for (int i = 0; i <= max; i++) begin
            if (bus.done) begin
                n     = i;
                found = 1'b1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            tick();
        end
        if (!found) n = -1;
    endtask

    task automatic issue(input md_op_t op, input logic sgn, input logic [15:0] a, input logic [7:0] b);
        bus.op    = op;
        bus.sgn   = sgn;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // Scramble inputs to prove they were latched on the start tick.
        bus.a     = ~a;
        bus.b     = ~b;
        bus.op    = (op == MD_MUL) ? MD_DIV : MD_MUL;
        bus.sgn   = ~sgn;
    endtask

    task automatic run_op(input string tag, input md_op_t op, input logic sgn,
                          input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] exp_q, input logic [15:0] exp_r);
        int n;
        bit busy_ok;
        issue(op, sgn, a, b);
        wait_done(60, n, busy_ok);
        check({tag, "_lat"},    n, md_latency(op, sgn, W));
        check({tag, "_busy"},   busy_ok, 1'b1);
        check({tag, "_res1"},   bus.res_1, exp_q);
        check({tag, "_res2"},   bus.res_2, exp_r);
        check({tag, "_bsyend"}, bus.busy, 1'b0);
        tick();
        check({tag, "_pulse"},  bus.done, 1'b0);
    endtask

    initial begin
        int  n;
        int  dones;
        bit  busy_ok;
        bit  hold_ok;

        reset      = 1'b1;
        bus.cpu_en = 1'b1;
        bus.start  = 1'b0;
        bus.op     = MD_MUL;
        bus.sgn    = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        tick();
        tick();
        check("rst_busy", bus.busy,  1'b0);
        check("rst_done", bus.done,  1'b0);
        check("rst_res1", bus.res_1, 16'h0000);
        check("rst_res2", bus.res_2, 16'h0000);
        reset = 1'b0;
        tick();

        // Unsigned arithmetic.
        run_op("umul_ff",  MD_MUL, 1'b0, 16'h00FF, 8'hFF, 16'h0000, 16'hFE01);
        run_op("umul_hi",  MD_MUL, 1'b0, 16'hAB0F, 8'h10, 16'h0000, 16'h00F0);
        run_op("udiv",     MD_DIV, 1'b0, 16'h1234, 8'h56, 16'h0036, 16'h0010);
        run_op("udiv_big", MD_DIV, 1'b0, 16'hFFFF, 8'hFF, 16'h0101, 16'h0000);
        run_op("udiv_one", MD_DIV, 1'b0, 16'hFFFF, 8'h01, 16'hFFFF, 16'h0000);

        // Divide by zero in both modes.
        run_op("udiv0",    MD_DIV, 1'b0, 16'hABCD, 8'h00, 16'hFFFF, 16'hABCD);
        run_op("sdiv0",    MD_DIV, 1'b1, 16'hABCD, 8'h00, 16'hFFFF, 16'hABCD);

        // Signed arithmetic and boundary cases.
        run_op("smul",     MD_MUL, 1'b1, 16'h00FE, 8'h03, 16'h0000, 16'hFFFA);
        run_op("smul_min", MD_MUL, 1'b1, 16'h0080, 8'h80, 16'h0000, 16'h4000);
        run_op("sdiv_nn",  MD_DIV, 1'b1, 16'hFF9C, 8'h07, 16'hFFF2, 16'hFFFE);
        run_op("sdiv_pn",  MD_DIV, 1'b1, 16'h0064, 8'hF9, 16'hFFF2, 16'h0002);
        run_op("sdiv_ovf", MD_DIV, 1'b1, 16'h8000, 8'hFF, 16'h8000, 16'h0000);

        // start with cpu_en low is ignored.
        bus.cpu_en = 1'b0;
        bus.op     = MD_DIV;
        bus.a      = 16'h1234;
        bus.b      = 8'h56;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cpu_en = 1'b1;
        tick();
        check("noen_busy", bus.busy, 1'b0);

        // Stall for 5 clocks in the middle of a divide.
        issue(MD_DIV, 1'b0, 16'h1234, 8'h56);
        for (int i = 0; i < 4; i++) tick();
        bus.cpu_en = 1'b0;
        hold_ok    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!bus.busy || bus.done) hold_ok = 1'b0;
        end
        bus.cpu_en = 1'b1;
        check("stall_hold", hold_ok, 1'b1);
        wait_done(60, n, busy_ok);
        check("stall_lat",  4 + 5 + n, 16 + 5);
        check("stall_res1", bus.res_1, 16'h0036);
        check("stall_res2", bus.res_2, 16'h0010);
        tick();

        // Restart with a multiply at tick 6 of a divide.
        dones = 0;
        issue(MD_DIV, 1'b0, 16'h1234, 8'h56);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) dones++;
        end
        issue(MD_MUL, 1'b0, 16'h0007, 8'h09);
        wait_done(60, n, busy_ok);
        if (n >= 0) dones++;
        check("abort_lat",  n, 8);
        check("abort_res2", bus.res_2, 16'h003F);
        check("abort_res1", bus.res_1, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort_dones", dones, 1);

        // Reset at tick 4 of a divide.
        issue(MD_DIV, 1'b0, 16'h1234, 8'h56);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", bus.busy,  1'b0);
        check("mrst_done", bus.done,  1'b0);
        check("mrst_res1", bus.res_1, 16'h0000);
        check("mrst_res2", bus.res_2, 16'h0000);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("mrst_nodone", dones, 0);
        run_op("post_rst", MD_DIV, 1'b0, 16'h1234, 8'h56, 16'h0036, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
